// File: rtl/led_pattern_sequencer.sv
// Multi-channel LED pattern sequencer: each channel shifts out a stored pattern LSB first,
// paced by one shared step prescaler, with double-buffered runtime reconfiguration.
module led_pattern_sequencer #(
    parameter int unsigned          N_CH         = 1,
    parameter int unsigned          PAT_LEN      = 32,
    parameter int unsigned          STEP_DIV     = 2097152,
    parameter logic [PAT_LEN-1:0]   DEFAULT_PAT  = 32'h05477715,
    parameter bit                   RUN_ON_RESET = 1'b1,
    parameter bit                   IDLE_LEVEL   = 1'b0,
    localparam int unsigned         CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned         IDX_W        = $clog2(PAT_LEN + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PAT_LEN-1:0]  cfg_pattern,
    input  logic [IDX_W-1:0]    cfg_len,
    input  logic                cfg_oneshot,
    input  logic [N_CH-1:0]     start,
    input  logic [N_CH-1:0]     stop,
    output logic [N_CH-1:0]     led,
    output logic [N_CH-1:0]     busy,
    output logic [N_CH-1:0]     wrap
);

    localparam int unsigned CNT_W = $clog2(STEP_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [IDX_W-1:0] cfg_len_n;

    assign tick  = (cnt_q == CNT_W'(STEP_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // Out-of-range lengths are folded to the full pattern once, at write time.
    assign cfg_len_n = ((cfg_len == '0) || (cfg_len > IDX_W'(PAT_LEN))) ? IDX_W'(PAT_LEN)
                                                                         : cfg_len;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_e             state_q, state_d;
        logic [PAT_LEN-1:0] act_pat_q, act_pat_d, sh_pat_q, sh_pat_d, shown;
        logic [IDX_W-1:0]   act_len_q, act_len_d, sh_len_q, sh_len_d, idx_q, idx_d;
        logic               act_one_q, act_one_d, sh_one_q, sh_one_d, pend_q, pend_d;
        logic               led_q, led_d, busy_q, busy_d, wrap_q, wrap_d;
        logic               wr, run_tick, last, apply;

        assign wr = cfg_we && (cfg_ch == CH_W'(c));

        always_comb begin
            sh_pat_d  = wr ? cfg_pattern : sh_pat_q;
            sh_len_d  = wr ? cfg_len_n : sh_len_q;
            sh_one_d  = wr ? cfg_oneshot : sh_one_q;
            pend_d    = pend_q | wr;
            act_pat_d = act_pat_q;
            act_len_d = act_len_q;
            act_one_d = act_one_q;
            state_d   = state_q;
            idx_d     = idx_q;
            wrap_d    = 1'b0;
            run_tick  = (state_q == StRun) && tick;
            last      = (idx_q == act_len_q - IDX_W'(1));
            // A running pass only adopts new config at a pass boundary or on restart.
            apply     = pend_d && ((state_q != StRun) ||
                                   (!stop[c] && (start[c] || (run_tick && last))));

            if (apply) begin
                act_pat_d = sh_pat_d;
                act_len_d = sh_len_d;
                act_one_d = sh_one_d;
                pend_d    = 1'b0;
                idx_d     = '0;
            end

            if (stop[c]) begin
                state_d = StIdle;
            end else if (start[c]) begin
                state_d = StRun;
                idx_d   = '0;
            end else if (run_tick) begin
                if (last) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                    if (act_one_d) begin
                        state_d = StDone;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            shown  = act_pat_q >> idx_q;
            led_d  = (state_q == StRun) ? shown[0] : IDLE_LEVEL;
            busy_d = (state_q == StRun);
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q   <= RUN_ON_RESET ? StRun : StIdle;
                act_pat_q <= DEFAULT_PAT;
                sh_pat_q  <= DEFAULT_PAT;
                act_len_q <= IDX_W'(PAT_LEN);
                sh_len_q  <= IDX_W'(PAT_LEN);
                act_one_q <= 1'b0;
                sh_one_q  <= 1'b0;
                pend_q    <= 1'b0;
                idx_q     <= '0;
                led_q     <= 1'b0;
                busy_q    <= RUN_ON_RESET;
                wrap_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                act_pat_q <= act_pat_d;
                sh_pat_q  <= sh_pat_d;
                act_len_q <= act_len_d;
                sh_len_q  <= sh_len_d;
                act_one_q <= act_one_d;
                sh_one_q  <= sh_one_d;
                pend_q    <= pend_d;
                idx_q     <= idx_d;
                led_q     <= led_d;
                busy_q    <= busy_d;
                wrap_q    <= wrap_d;
            end
        end

        assign led[c]  = led_q;
        assign busy[c] = busy_q;
        assign wrap[c] = wrap_q;
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer; expectations are queued per cycle and checked
// against the DUT outputs one cycle at a time.
module tb_led_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_we, cfg_ch, cfg_oneshot;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [1:0] start, stop, led, busy, wrap;
    // Three-channel instance so that a channel number past the last one is expressible.
    logic       cfg_we3;
    logic [1:0] cfg_ch3;
    logic [2:0] start3, stop3, led3, busy3, wrap3;

    always #5 CLK = ~CLK;

    led_pattern_sequencer #(
        .N_CH(2), .PAT_LEN(8), .STEP_DIV(4), .DEFAULT_PAT(8'h15),
        .RUN_ON_RESET(1'b1), .IDLE_LEVEL(1'b0)
    ) u_dut (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
        .led(led), .busy(busy), .wrap(wrap)
    );

    led_pattern_sequencer #(
        .N_CH(3), .PAT_LEN(8), .STEP_DIV(4), .DEFAULT_PAT(8'h15),
        .RUN_ON_RESET(1'b1), .IDLE_LEVEL(1'b0)
    ) u_dut3 (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .start(start3), .stop(stop3),
        .led(led3), .busy(busy3), .wrap(wrap3)
    );

    typedef struct packed {
        logic [1:0] led;
        logic [1:0] busy;
        logic [1:0] wrap;
        logic [1:0] m;
        logic       chk3;
        logic [2:0] led3;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic cmp(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        cfg_we  = 1'b0;
        cfg_we3 = 1'b0;
        start   = '0;
        stop    = '0;
    endtask

    function automatic void push(logic [1:0] l, logic [1:0] b, logic [1:0] w, logic [1:0] m,
                                 logic c3 = 1'b0, logic [2:0] l3 = 3'b000);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.wrap = w;
        e.m    = m;
        e.chk3 = c3;
        e.led3 = l3;
        sb.push_back(e);
    endfunction

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) begin
            step();
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL %s.queue cyc=%0d: observed empty expected entry", tag, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                cmp({tag, ".led"},  8'(led & e.m),  8'(e.led & e.m));
                cmp({tag, ".busy"}, 8'(busy & e.m), 8'(e.busy & e.m));
                cmp({tag, ".wrap"}, 8'(wrap & e.m), 8'(e.wrap & e.m));
                if (e.chk3) begin
                    cmp({tag, ".led3"},  8'(led3),  8'(e.led3));
                    cmp({tag, ".busy3"}, 8'(busy3), 8'h07);
                    cmp({tag, ".wrap3"}, 8'(wrap3), 8'({3{e.wrap[0]}}));
                end
            end
        end
    endtask

    // Bit shown c cycles after a step-aligned (re)start, for a 4-cycle step and 8-bit pattern.
    function automatic logic pbit(logic [7:0] p, int c);
        logic [7:0] t;
        t = p >> (((c - 1) / 4) % 8);
        return t[0];
    endfunction

    function automatic logic wr32(int c);
        return (c > 0) && ((c % 32) == 0);
    endfunction

    initial begin
        int   j0, w0, b0, n;
        logic bt, wt, on;

        cfg_we = 0; cfg_we3 = 0; cfg_ch = 0; cfg_ch3 = 0; cfg_pattern = 0; cfg_len = 0;
        cfg_oneshot = 0; start = 0; stop = 0; start3 = 0; stop3 = 0;

        RST = 1'b1;
        repeat (3) step();
        cmp("reset.led",   8'(led),   8'h00);
        cmp("reset.busy",  8'(busy),  8'h03);
        cmp("reset.wrap",  8'(wrap),  8'h00);
        cmp("reset.led3",  8'(led3),  8'h00);
        cmp("reset.busy3", 8'(busy3), 8'h07);

        RST = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 64; c++) begin
            bt = pbit(8'h15, c);
            wt = wr32(c);
            push({bt, bt}, 2'b11, {wt, wt}, 2'b11, 1'b1, {3{bt}});
        end
        run(64, "default");

        // Channel 1: one-shot all-ones pattern of length 3, started on a step boundary.
        while (cyc % 4 != 2) step();
        cfg_we = 1; cfg_ch = 1; cfg_pattern = 8'hFF; cfg_len = 3; cfg_oneshot = 1;
        step();
        start = 2'b10;
        step();
        j0 = cyc;
        for (int c = j0 + 1; c <= j0 + 16; c++) begin
            on = (c <= j0 + 12);
            bt = pbit(8'h15, c);
            push({on, bt}, {on, 1'b1}, {c == j0 + 12, wr32(c)}, 2'b11);
        end
        run(16, "oneshot");

        // Channel 0: new pattern mid-pass with len 0, takes effect only after the wrap.
        while (cyc % 32 != 10) step();
        cfg_we = 1; cfg_ch = 0; cfg_pattern = 8'h0F; cfg_len = 0; cfg_oneshot = 0;
        step();
        w0 = cyc - 11;
        n = w0 + 64 - cyc;
        for (int c = cyc + 1; c <= w0 + 64; c++) begin
            bt = pbit((c <= w0 + 32) ? 8'h15 : 8'h0F, c);
            push({1'b0, bt}, 2'b01, {1'b0, wr32(c)}, 2'b11);
        end
        run(n, "midpass");

        // Simultaneous start and stop: stop wins.
        step();
        start = 2'b01; stop = 2'b01;
        step();
        for (int c = 0; c < 4; c++) push(2'b00, 2'b00, 2'b00, 2'b11);
        run(4, "startstop");

        while (cyc % 4 != 3) step();
        start = 2'b01;
        step();
        b0 = cyc;
        for (int c = b0 + 1; c <= b0 + 32; c++) begin
            bt = pbit(8'h0F, c - b0);
            push({1'b0, bt}, 2'b01, {1'b0, (c - b0) == 32}, 2'b11);
        end
        run(32, "restart");

        // Pending write lost across reset.
        repeat (6) step();
        cfg_we = 1; cfg_ch = 0; cfg_pattern = 8'hAA; cfg_len = 9; cfg_oneshot = 1;
        step();
        RST = 1'b1;
        step();
        step();
        cmp("reset2.led",  8'(led),  8'h00);
        cmp("reset2.busy", 8'(busy), 8'h03);
        cmp("reset2.wrap", 8'(wrap), 8'h00);

        RST = 1'b0;
        cyc = 0;
        cfg_we3 = 1; cfg_ch3 = 2'd3; cfg_pattern = 8'h00; cfg_len = 1; cfg_oneshot = 1;
        for (int c = 1; c <= 40; c++) begin
            bt = pbit(8'h15, c);
            wt = wr32(c);
            push({bt, bt}, 2'b11, {wt, wt}, 2'b11, 1'b1, {3{bt}});
        end
        run(40, "postreset");

        // Length-1 loop: bit 0 repeats and wrap fires every step.
        cfg_we = 1; cfg_ch = 1; cfg_pattern = 8'hFE; cfg_len = 1; cfg_oneshot = 0;
        step();
        while (cyc % 4 != 3) step();
        start = 2'b10;
        step();
        b0 = cyc;
        for (int c = b0 + 1; c <= b0 + 12; c++) begin
            bt = pbit(8'h15, c);
            push({1'b0, bt}, 2'b11, {((c - b0) % 4) == 0, wr32(c)}, 2'b11);
        end
        run(12, "len1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
